// File: rtl/fp_preadder_pipe_if.sv
// Operand/result bundle for the FP pre-adder: valid/ready on both sides plus the aligned-pair result.
interface fp_preadder_pipe_if #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
);
  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int MW = MAN_W + 5;

  logic             in_valid;
  logic             in_ready;
  logic             op_sub;
  logic [W-1:0]     number_A;
  logic [W-1:0]     number_B;
  logic             out_valid;
  logic             out_ready;
  logic             sign_of_great;
  logic             sign_of_small;
  logic [EXP_W-1:0] exp;
  logic [MW-1:0]    mantis_great;
  logic [MW-1:0]    mantis_small;
  logic [W-1:0]     special_result;
  logic             special_case;
  logic             loss;

  modport master (
    output in_valid, op_sub, number_A, number_B, out_ready,
    input  in_ready, out_valid, sign_of_great, sign_of_small, exp,
           mantis_great, mantis_small, special_result, special_case, loss
  );

  modport slave (
    input  in_valid, op_sub, number_A, number_B, out_ready,
    output in_ready, out_valid, sign_of_great, sign_of_small, exp,
           mantis_great, mantis_small, special_result, special_case, loss
  );
endinterface

// File: rtl/fp_preadder_pipe.sv
// FP add/sub pre-adder: classify, resolve specials, order and align operands; 2-cycle latency.
// Both stages advance together on !out_valid | out_ready; in_ready follows that combinationally.
module fp_preadder_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input logic              clk,
  input logic              rst,
  fp_preadder_pipe_if.slave bus
);
  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int MW = MAN_W + 5;

  localparam logic [EXP_W-1:0] EXP_ONES = '1;
  localparam logic [EXP_W-1:0] EXP_ONE  = EXP_W'(1);
  localparam logic [EXP_W-1:0] D_MAX    = EXP_W'(MAN_W + 4);
  localparam logic [W-1:0]     QNAN     = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};

  logic adv;
  assign adv          = !bus.out_valid || bus.out_ready;
  assign bus.in_ready = adv;

  // ---------------- decode / classify ----------------
  logic             sa, sb;
  logic [EXP_W-1:0] ea, eb, eea, eeb;
  logic [MAN_W-1:0] ma, mb;
  logic             zero_a, zero_b, inf_a, inf_b, nan_a, nan_b, a_great;

  assign sa = bus.number_A[W-1];
  assign sb = bus.number_B[W-1] ^ bus.op_sub;
  assign ea = bus.number_A[W-2 -: EXP_W];
  assign eb = bus.number_B[W-2 -: EXP_W];
  assign ma = bus.number_A[MAN_W-1:0];
  assign mb = bus.number_B[MAN_W-1:0];

  assign zero_a = (ea == '0) && (ma == '0);
  assign zero_b = (eb == '0) && (mb == '0);
  assign inf_a  = (ea == EXP_ONES) && (ma == '0);
  assign inf_b  = (eb == EXP_ONES) && (mb == '0);
  assign nan_a  = (ea == EXP_ONES) && (ma != '0);
  assign nan_b  = (eb == EXP_ONES) && (mb != '0);
  assign eea    = (ea == '0) ? EXP_ONE : ea;
  assign eeb    = (eb == '0) ? EXP_ONE : eb;

  // Raw {exp,man} ordering matches effective-exponent ordering since subnormals sit below exp 1.
  assign a_great = {ea, ma} >= {eb, mb};

  logic         c_special;
  logic [W-1:0] c_res;

  always_comb begin
    c_special = 1'b1;
    c_res     = '0;
    if (nan_a || nan_b)                  c_res = QNAN;
    else if (inf_a && inf_b && (sa != sb)) c_res = QNAN;
    else if (inf_a)                      c_res = {sa, EXP_ONES, {MAN_W{1'b0}}};
    else if (inf_b)                      c_res = {sb, EXP_ONES, {MAN_W{1'b0}}};
    else if (zero_a && zero_b)           c_res = {sa & sb, {(W-1){1'b0}}};
    else if (zero_a)                     c_res = {sb, eb, mb};
    else if (zero_b)                     c_res = {sa, ea, ma};
    else                                 c_special = 1'b0;
  end

  // ---------------- stage 1 ----------------
  logic             s1_vld, s1_special, s1_sg, s1_ss;
  logic [W-1:0]     s1_res;
  logic [EXP_W-1:0] s1_exp, s1_d;
  logic [MAN_W:0]   s1_man_g, s1_man_s;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld     <= 1'b0;
      s1_special <= 1'b0;
      s1_res     <= '0;
      s1_sg      <= 1'b0;
      s1_ss      <= 1'b0;
      s1_exp     <= '0;
      s1_d       <= '0;
      s1_man_g   <= '0;
      s1_man_s   <= '0;
    end else if (adv) begin
      s1_vld <= bus.in_valid;
      if (bus.in_valid) begin
        s1_special <= c_special;
        s1_res     <= c_res;
        if (a_great) begin
          s1_sg    <= sa;
          s1_ss    <= sb;
          s1_exp   <= eea;
          s1_d     <= eea - eeb;
          s1_man_g <= {ea != '0, ma};
          s1_man_s <= {eb != '0, mb};
        end else begin
          s1_sg    <= sb;
          s1_ss    <= sa;
          s1_exp   <= eeb;
          s1_d     <= eeb - eea;
          s1_man_g <= {eb != '0, mb};
          s1_man_s <= {ea != '0, ma};
        end
      end
    end
  end

  // ---------------- alignment ----------------
  logic [MW-1:0] full_s, mask, al_small;
  logic          small_nz, al_loss;

  assign full_s   = {1'b0, s1_man_s, 3'b000};
  assign small_nz = |s1_man_s;

  always_comb begin
    mask     = '0;
    al_small = '0;
    al_loss  = 1'b0;
    if (s1_d >= D_MAX) begin
      al_small = {{(MW-1){1'b0}}, small_nz};
      al_loss  = small_nz;
    end else begin
      mask     = ~({MW{1'b1}} << s1_d);
      al_loss  = |(full_s & mask);
      al_small = (full_s >> s1_d) | {{(MW-1){1'b0}}, al_loss};
    end
  end

  // ---------------- stage 2 / outputs ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.out_valid      <= 1'b0;
      bus.special_case   <= 1'b0;
      bus.special_result <= '0;
      bus.sign_of_great  <= 1'b0;
      bus.sign_of_small  <= 1'b0;
      bus.exp            <= '0;
      bus.mantis_great   <= '0;
      bus.mantis_small   <= '0;
      bus.loss           <= 1'b0;
    end else if (adv) begin
      bus.out_valid      <= s1_vld;
      bus.special_case   <= s1_special;
      bus.special_result <= s1_special ? s1_res : '0;
      bus.sign_of_great  <= s1_special ? 1'b0 : s1_sg;
      bus.sign_of_small  <= s1_special ? 1'b0 : s1_ss;
      bus.exp            <= s1_special ? '0 : s1_exp;
      bus.mantis_great   <= s1_special ? '0 : {1'b0, s1_man_g, 3'b000};
      bus.mantis_small   <= s1_special ? '0 : al_small;
      bus.loss           <= s1_special ? 1'b0 : al_loss;
    end
  end
endmodule
